// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 UART receiver, LSB first, mid-bit sampling with a
//             free-running bit-period divider and a 2-flop input synchronizer.
//  Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int DIV_CNT   = 433,
    parameter int DIV_CNT_W = 9,
    parameter int BIT_CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_end,
    output logic [7:0] rx_data
);

    localparam logic [DIV_CNT_W-1:0] c_DIV_MAX  = DIV_CNT_W'(DIV_CNT);
    localparam logic [DIV_CNT_W-1:0] c_DIV_HALF = DIV_CNT_W'(DIV_CNT / 2);
    localparam logic [BIT_CNT_W-1:0] c_LAST_BIT = BIT_CNT_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 rx_s;
    state_t               state_q,   state_d;
    logic [DIV_CNT_W-1:0] div_q,     div_d;
    logic [DIV_CNT_W-1:0] div_next;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q,   shift_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_end_q,  rx_end_d;

    assign rx_s     = sync2_q;
    assign div_next = (div_q == c_DIV_MAX) ? '0 : div_q + DIV_CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rx_end_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    div_d   = '0;
                end
            end
            ST_START: begin
                if (div_q == c_DIV_HALF) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        div_d     = '0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_next;
                end
            end
            ST_DATA: begin
                // The wrap to 0 after DIV_CNT restarts the divider for the next bit.
                div_d = div_next;
                if (div_q == c_DIV_MAX) begin
                    shift_d[bit_cnt_q[2:0]] = rx_s;
                    if (bit_cnt_q == c_LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                div_d = div_next;
                if (div_q == c_DIV_MAX) begin
                    if (rx_s) begin
                        rx_data_d = shift_q;
                        rx_end_d  = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= 8'h00;
            rx_data_q <= 8'h00;
            rx_end_q  <= 1'b0;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rx_end_q  <= rx_end_d;
        end
    end

    assign rx_end  = rx_end_q;
    assign rx_data = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Brief    : Directed, table-driven bench for uart_rx at the default baud.
//  Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int DIV_CNT = 433;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rx_end;
    logic [7:0] rx_data;

    int n_vec;
    int n_bad;
    int end_cnt;
    int wide_cnt;
    logic       prev_end;
    logic [7:0] last_data;

    uart_rx #(
        .DIV_CNT  (DIV_CNT),
        .DIV_CNT_W(9),
        .BIT_CNT_W(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .rx_end (rx_end),
        .rx_data(rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts completion strobes and flags any that last >1 cycle.
    always @(negedge clk) begin
        if (rx_end) begin
            end_cnt   = end_cnt + 1;
            last_data = rx_data;
            if (prev_end) wide_cnt = wide_cnt + 1;
        end
        prev_end = rx_end;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_bits;
        int         idle_after;
        int         exp_ends;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        repeat (DIV_CNT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        rx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int base;
        n_vec    = 0;
        n_bad    = 0;
        end_cnt  = 0;
        wide_cnt = 0;
        prev_end = 1'b0;
        last_data = 8'h00;

        // data, stop, low bits after stop, idle after, expected strobes, expected rx_data
        vecs[0] = '{8'h6A, 1'b1, 0, 500, 1, 8'h6A};
        vecs[1] = '{8'h55, 1'b1, 0, 0,   1, 8'h55};
        vecs[2] = '{8'hA3, 1'b1, 0, 200, 1, 8'hA3};
        vecs[3] = '{8'hFF, 1'b0, 3, 50,  0, 8'hA3};
        vecs[4] = '{8'h12, 1'b1, 0, 100, 1, 8'h12};

        rx  = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_rx_end", int'(rx_end), 0);
        check("reset_rx_data", int'(rx_data), 8'h00);

        repeat (300) @(negedge clk);
        check("idle_no_end", end_cnt, 0);
        check("idle_rx_data", int'(rx_data), 8'h00);

        for (int v = 0; v < 5; v++) begin
            base = end_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            if (vecs[v].low_bits > 0) begin
                for (int k = 0; k < vecs[v].low_bits; k++) send_bit(1'b0);
            end
            check($sformatf("vec%0d_ends", v), end_cnt - base, vecs[v].exp_ends);
            if (vecs[v].exp_ends > 0)
                check($sformatf("vec%0d_strobe_data", v), int'(last_data), int'(vecs[v].exp_data));
            if (vecs[v].idle_after > 0) idle(vecs[v].idle_after);
            check($sformatf("vec%0d_rx_data", v), int'(rx_data), int'(vecs[v].exp_data));
        end

        // Glitch shorter than half a bit must be rejected.
        base = end_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV_CNT / 4) @(negedge clk);
        idle(600);
        check("glitch_no_end", end_cnt - base, 0);
        check("glitch_rx_data", int'(rx_data), 8'h12);
        send_frame(8'h3C, 1'b1);
        idle(50);
        check("after_glitch_ends", end_cnt - base, 1);
        check("after_glitch_data", int'(rx_data), 8'h3C);

        // Reset during bit 4 of a frame aborts it and clears rx_data.
        base = end_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_rx_data", int'(rx_data), 8'h00);
        idle(2 * (DIV_CNT + 1));
        check("midrst_no_end", end_cnt - base, 0);
        check("midrst_rx_data_held", int'(rx_data), 8'h00);
        send_frame(8'h81, 1'b1);
        idle(50);
        check("after_rst_ends", end_cnt - base, 1);
        check("after_rst_data", int'(rx_data), 8'h81);

        check("strobe_width", wide_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
